// File: rtl/vram_arbiter.sv
// Single-port sprite VRAM arbiter: scan-out reads have strict priority, host
// accesses use a req/ack handshake and fill the free issue slots.
module vram_arbiter #(
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_WIDTH        = 8,
  parameter bit BLANK_ONLY_WRITES = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  video_enable,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic                  host_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, PEND, RD_WAIT, DONE} state_t;

  state_t                  state, state_nx;
  logic                    rd_cnt, rd_cnt_nx;
  logic                    pend_we;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [DATA_WIDTH-1:0]   pend_wdata;
  logic [1:0]              vid_tag;
  logic                    host_grant;

  // Writes may be held off during active display to avoid tearing; reads never are.
  assign host_grant = (state == PEND) && !vid_req &&
                      (!pend_we || !BLANK_ONLY_WRITES || !video_enable);

  assign host_ack  = (state == DONE);
  assign host_busy = (state != IDLE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_nx  = state;
    rd_cnt_nx = rd_cnt;
    case (state)
      IDLE:    if (host_req) state_nx = PEND;
      PEND: begin
        if (host_grant) begin
          if (pend_we) begin
            state_nx = DONE;
          end else begin
            state_nx  = RD_WAIT;
            rd_cnt_nx = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (rd_cnt == 1'b0) state_nx = DONE;
        else                rd_cnt_nx = 1'b0;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_cnt     <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      host_rdata <= '0;
    end else begin
      state  <= state_nx;
      rd_cnt <= rd_cnt_nx;
      if (state == IDLE && host_req) begin
        pend_we    <= host_we;
        pend_addr  <= host_addr;
        pend_wdata <= host_wdata;
      end
      if (state == RD_WAIT && rd_cnt == 1'b0) host_rdata <= mem_rdata;
    end
  end

  // VRAM issue port: at most one access loaded per edge, video first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
    end else if (vid_req) begin
      mem_addr  <= vid_addr;
      mem_write <= 1'b0;
    end else if (host_grant) begin
      mem_addr  <= pend_addr;
      mem_write <= pend_we;
      if (pend_we) mem_wdata <= pend_wdata;
    end else begin
      mem_write <= 1'b0;
    end
  end

  // Tag shift register tracks video reads through the SRAM's registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_tag   <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      vid_tag   <= {vid_tag[0], vid_req};
      vid_valid <= vid_tag[1];
      if (vid_tag[1]) vid_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural VRAM, spec-level timing
// model feeding scoreboard queues, and a negedge monitor that pops and compares.
module tb_vram_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam bit BLANK = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          video_enable = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] host_rdata;
  logic          host_ack;
  logic          host_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLANK_ONLY_WRITES(BLANK)) dut (
    .clk(clk), .rst(rst), .video_enable(video_enable),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_busy(host_busy), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read single-port SRAM.
  logic [DW-1:0] vram      [1<<AW];
  logic [DW-1:0] model_mem [1<<AW];
  always @(posedge clk) begin
    if (mem_write) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [DW-1:0] data; } vexp_t;
  typedef struct { int due; logic we; logic [DW-1:0] data; } hexp_t;
  typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;

  vexp_t vq[$];
  hexp_t hq[$];
  wexp_t wq[$];

  // Host model: 0 = idle, 1 = waiting for a free slot, 2 = granted, awaiting ack.
  int            m_phase = 0;
  int            m_ack   = 0;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  vexp_t         ve;
  hexp_t         he;
  wexp_t         we_r;

  always @(negedge clk) begin
    if (rst) begin
      vq.delete(); hq.delete(); wq.delete();
      m_phase = 0;
    end else begin
      if (vid_valid) begin
        if (vq.size() == 0) check("vid_unexpected", {31'd0, vid_valid}, 32'd0);
        else begin
          ve = vq.pop_front();
          check("vid_cycle", cyc, ve.due);
          check("vid_data", {24'd0, vid_data}, {24'd0, ve.data});
        end
      end else if (vq.size() != 0 && vq[0].due <= cyc) begin
        check("vid_missing", {31'd0, vid_valid}, 32'd1);
        void'(vq.pop_front());
      end

      if (host_ack) begin
        if (hq.size() == 0) check("ack_unexpected", {31'd0, host_ack}, 32'd0);
        else begin
          he = hq.pop_front();
          check("ack_cycle", cyc, he.due);
          if (!he.we) check("host_rdata", {24'd0, host_rdata}, {24'd0, he.data});
        end
      end else if (hq.size() != 0 && hq[0].due <= cyc) begin
        check("ack_missing", {31'd0, host_ack}, 32'd1);
        void'(hq.pop_front());
      end

      if (mem_write) begin
        if (wq.size() == 0) check("write_unexpected", {31'd0, mem_write}, 32'd0);
        else begin
          we_r = wq.pop_front();
          check("write_cycle", cyc, we_r.due);
          check("write_addr", {22'd0, mem_addr}, {22'd0, we_r.addr});
          check("write_data", {24'd0, mem_wdata}, {24'd0, we_r.data});
        end
      end else if (wq.size() != 0 && wq[0].due <= cyc) begin
        check("write_missing", {31'd0, mem_write}, 32'd1);
        void'(wq.pop_front());
      end

      check("host_busy", {31'd0, host_busy}, {31'd0, m_phase != 0});

      // Video read data is whatever memory holds once all earlier grants have landed.
      if (vid_req) vq.push_back('{due: cyc + 3, data: model_mem[vid_addr]});

      if (m_phase == 0) begin
        if (host_req) begin
          m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!vid_req && (!m_we || !BLANK || !video_enable)) begin
          m_ack = cyc + (m_we ? 1 : 3);
          if (m_we) begin
            wq.push_back('{due: cyc + 1, addr: m_addr, data: m_wdata});
            model_mem[m_addr] = m_wdata;
            hq.push_back('{due: m_ack, we: 1'b1, data: '0});
          end else begin
            hq.push_back('{due: m_ack, we: 1'b0, data: model_mem[m_addr]});
          end
          m_phase = 2;
        end
      end else if (cyc >= m_ack) begin
        m_phase = 0;
      end
    end
  end

  task automatic vid_cycle(input logic req, input logic [AW-1:0] a, input logic ven);
    vid_req = req; vid_addr = a; video_enable = ven;
    @(posedge clk); #1;
  endtask

  task automatic host_xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] rd);
    int r;
    bit got;
    r = cyc; got = 0; lat = -1; rd = '0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (host_ack) begin got = 1; lat = cyc - r; rd = host_rdata; end
    end
    if (!got) check("host_timeout", {31'd0, host_ack}, 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vid_valid"},  {31'd0, vid_valid}, 32'd0);
    check({tag, "_vid_data"},   {24'd0, vid_data},  32'd0);
    check({tag, "_host_ack"},   {31'd0, host_ack},  32'd0);
    check({tag, "_host_busy"},  {31'd0, host_busy}, 32'd0);
    check({tag, "_host_rdata"}, {24'd0, host_rdata}, 32'd0);
    check({tag, "_mem_addr"},   {22'd0, mem_addr},  32'd0);
    check({tag, "_mem_write"},  {31'd0, mem_write}, 32'd0);
    check({tag, "_mem_wdata"},  {24'd0, mem_wdata}, 32'd0);
  endtask

  int            lat;
  logic [DW-1:0] rd;
  logic [DW-1:0] v;
  bit            vid_done;
  logic          ven_r;
  int            run_left;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      vram[i] <= v;
      model_mem[i] = v;
    end
    vram[5] <= 8'h3C;
    model_mem[5] = 8'h3C;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) vid_cycle(1'b0, '0, 1'b0);
    check_all_zero("idle");

    // Single video read of the known word, then a 32-deep back-to-back burst.
    vid_cycle(1'b1, 10'h005, 1'b1);
    repeat (5) vid_cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 32; i++) vid_cycle(1'b1, AW'(i), 1'b1);
    repeat (4) vid_cycle(1'b0, '0, 1'b0);

    // Uncontended host write then read-back.
    host_xact(1'b1, 10'h3FF, 8'hA5, lat, rd);
    check("wr_latency", lat, 2);
    host_xact(1'b0, 10'h3FF, 8'h00, lat, rd);
    check("rd_latency", lat, 4);
    check("rd_data", {24'd0, rd}, 32'h0000_00A5);

    // Write held through active display with toggling scan-out, released in blanking.
    fork
      begin
        for (int i = 0; i < 12; i++) vid_cycle(logic'(i % 2), AW'(100 + i), 1'b1);
        vid_cycle(1'b1, 10'h007, 1'b0);
        repeat (5) vid_cycle(1'b0, '0, 1'b0);
      end
      host_xact(1'b1, 10'h200, 8'h5A, lat, rd);
    join
    check("blank_wr_latency", lat, 14);

    // Read stalled by ten consecutive scan-out reads.
    fork
      begin
        for (int i = 0; i < 10; i++) vid_cycle(1'b1, AW'(32 + i), 1'b1);
        repeat (6) vid_cycle(1'b0, '0, 1'b1);
      end
      host_xact(1'b0, 10'h3FF, 8'h00, lat, rd);
    join
    check("contended_rd_latency", lat, 13);
    check("contended_rd_data", {24'd0, rd}, 32'h0000_00A5);

    // Randomized traffic.
    vid_done = 0; ven_r = 1'b1; run_left = 0;
    fork
      begin
        for (int c = 0; c < 800; c++) begin
          if (run_left == 0) begin
            ven_r = ~ven_r;
            run_left = $urandom_range(5, 40);
          end
          run_left--;
          vid_cycle(logic'($urandom_range(0, 99) < 55), AW'($urandom), ven_r);
        end
        vid_done = 1;
        vid_req = 1'b0; video_enable = 1'b0;
      end
      begin
        while (!vid_done) begin
          host_xact(logic'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), lat, rd);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (6) vid_cycle(1'b0, '0, 1'b0);

    // Reset while a host read sits in RD_WAIT with a video tag in flight.
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3FF;
    @(posedge clk); #1;
    host_req = 1'b0;
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 10'h005;
    @(posedge clk); #1;
    vid_req = 1'b0;
    check("rdwait_busy", {31'd0, host_busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_ack", {31'd0, host_ack}, 32'd0);
      check("post_reset_vid_valid", {31'd0, vid_valid}, 32'd0);
    end
    check("post_reset_idle", {31'd0, host_busy}, 32'd0);
    @(posedge clk); #1;
    host_xact(1'b0, 10'h3FF, 8'h00, lat, rd);
    check("recover_rd_latency", lat, 4);
    check("recover_rd_data", {24'd0, rd}, 32'h0000_00A5);

    repeat (6) vid_cycle(1'b0, '0, 1'b0);
    check("vid_queue_drained", vq.size(), 0);
    check("host_queue_drained", hq.size(), 0);
    check("write_queue_drained", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port sprite VRAM (registered-read SRAM, 1-cycle read latency) between the SVGA scan-out reader and a host port that loads and inspects sprite bitmaps. Scan-out has strict priority every cycle. Host accesses use a req/ack handshake and take only free slots. Host writes can be restricted to blanking to prevent tearing. The block sits between the pixel-address generator, the host bus, and the VRAM instance.

## Interface
- ADDR_WIDTH, 10, VRAM address width (32x32 sprite)
- DATA_WIDTH, 8, VRAM word width (palette index)
- BLANK_ONLY_WRITES, 1, when 1 host writes are granted only while video_enable=0
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- video_enable  in  1  active display area flag from SVGA sync
- vid_req  in  1  scan-out read request this cycle
- vid_addr  in  ADDR_WIDTH  scan-out read address
- vid_data  out  DATA_WIDTH  scan-out read data
- vid_valid  out  1  vid_data valid
- host_req  in  1  host request, held stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_rdata  out  DATA_WIDTH  host read data, valid with host_ack on reads
- host_ack  out  1  one-cycle completion pulse
- host_busy  out  1  FSM not in IDLE
- mem_addr  out  ADDR_WIDTH  to VRAM i_addr, registered
- mem_write  out  1  to VRAM i_write, registered
- mem_wdata  out  DATA_WIDTH  to VRAM i_data, registered
- mem_rdata  in  DATA_WIDTH  from VRAM o_data

## Operation
- One VRAM issue per cycle, at most. Issue means mem_addr/mem_write/mem_wdata are loaded at the clock edge.
- Priority: if vid_req=1, issue the video read (mem_write<=0). Otherwise a pending host access may issue.
- Host grant condition in PEND: vid_req=0 AND (host_we=0 OR BLANK_ONLY_WRITES=0 OR video_enable=0).
- Idle issue cycles: hold mem_addr, mem_write<=0.
- Host FSM:
  - IDLE: host_req=1 → capture addr/we/wdata into pending regs, go to PEND.
  - PEND: on grant, a write goes to DONE. A read goes to RD_WAIT with a 2-cycle countdown.
  - RD_WAIT: on countdown expiry, capture mem_rdata into host_rdata and go to DONE.
  - DONE: host_ack=1 for exactly this cycle. host_req is ignored. Next state is IDLE.
- Host protocol:
  - The host deasserts host_req, or presents a new request, in the cycle after the ack.
  - A request sampled in IDLE on the cycle after DONE starts a new transaction.
- Video pipeline: a 2-stage valid shift register tags video issues. The tag exits at the end of the third cycle; on exit, mem_rdata is captured into vid_data and vid_valid<=1. vid_valid is 0 otherwise.
- Host-read and video tags coexist in flight. They never collide because only one access issues per cycle.
- Pending regs are frozen from capture until DONE. Input changes meanwhile are ignored.

## Timing
- Reset values (asynchronous): state=IDLE; vid_data=0, vid_valid=0, host_rdata=0, host_ack=0, host_busy=0, mem_addr=0, mem_write=0, mem_wdata=0; tag pipeline cleared.
- Video latency: vid_req in cycle n → vid_valid/vid_data in cycle n+3. Throughput is 1 per cycle.
- Host write: req in cycle r, uncontended → grant in r+1. mem_write=1 and host_ack=1 in r+2.
- Host read: req in cycle r, uncontended → grant in r+1; host_ack and host_rdata in r+4.
- Contention: each cycle with vid_req=1 in PEND delays the grant 1 cycle. Host waits are unbounded by design; scan-out is never stalled.
- BLANK_ONLY_WRITES=1: a write held in PEND throughout the active area issues in the first cycle with video_enable=0 and vid_req=0.
- Reset mid-transaction: no ack is emitted and in-flight tags are discarded. After release, the host must re-present its request.
- host_busy=1 in PEND, RD_WAIT and DONE.

## Test plan
- Reset then idle: all outputs 0. vid_req pulse addr=0x005 with VRAM[5]=0x3C → vid_valid=1, vid_data=0x3C exactly 3 cycles later.
- Back-to-back video reads on addr 0..31, 32 consecutive cycles → 32 consecutive vid_valid with data in order.
- Host write addr=0x3FF data=0xA5, vid_req=0, video_enable=0 → mem_write=1 and host_ack=1 two cycles after req. A subsequent host read of 0x3FF returns 0xA5 with ack 4 cycles after req.
- BLANK_ONLY_WRITES=1, host write issued with video_enable=1 and vid_req toggling → no mem_write until video_enable=0 and vid_req=0. Ack follows one cycle later; video data is unaffected.
- Host read with vid_req=1 for 10 cycles → video reads all valid at +3 each; host grant in the first vid_req=0 cycle, ack 3 cycles after the grant.
- Assert reset while a host read is in RD_WAIT → host_ack never pulses; all outputs 0 immediately; FSM in IDLE after release.
